// File: rtl/instr_fetch_buffer_pkg.sv
// Shared types for the RV32I instruction fetch buffer: FIFO entry, FSM state,
// address step and a saturating adder used by the FETCH_STATS_EN counters.
package rv32i_fetch_pkg;

    typedef struct packed {
        logic [31:0] code;
        logic [31:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// Fetch-stage bus: memory request/response channel, core valid/ready channel
// and redirect control. FETCH_STATS_EN adds the two statistics outputs.
interface instr_fetch_buffer_if;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_code;
    logic [31:0] instr_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;

    modport master (
        input  fetch_en, redirect, redirect_pc, mem_rvalid, mem_rdata, instr_ready,
        output mem_req, mem_addr, instr_valid, instr_code, instr_pc,
        output stat_fetched, stat_flushed
    );
    modport slave (
        output fetch_en, redirect, redirect_pc, mem_rvalid, mem_rdata, instr_ready,
        input  mem_req, mem_addr, instr_valid, instr_code, instr_pc,
        input  stat_fetched, stat_flushed
    );
`else
    modport master (
        input  fetch_en, redirect, redirect_pc, mem_rvalid, mem_rdata, instr_ready,
        output mem_req, mem_addr, instr_valid, instr_code, instr_pc
    );
    modport slave (
        output fetch_en, redirect, redirect_pc, mem_rvalid, mem_rdata, instr_ready,
        input  mem_req, mem_addr, instr_valid, instr_code, instr_pc
    );
`endif
endinterface

// File: rtl/instr_fetch_buffer_fifo.sv
// Small synchronous FIFO of fetch entries with flush; pop and push may coincide
// even when full. Used both as the instruction buffer and the in-flight PC queue.
module fetch_fifo
    import rv32i_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_entry_t           data_i,
    output fetch_entry_t           data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: storage is not reset; the head output is forced to zero while empty instead.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch stage: credit-limited sequential fetch, in-order response
// buffering and redirect flush with stale-response discard. Option: FETCH_STATS_EN.
module instr_fetch_buffer
    import rv32i_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  rst,
    instr_fetch_buffer_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t state_q;
    logic [31:0]  pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] fifo_count, pcq_count;
    logic          fifo_empty, fifo_full, pcq_empty, pcq_full;
    fetch_entry_t  head, pcq_head;
    logic          issue, resp_take, drop, keep, pop;

    // Credits cover both buffered entries and responses still owed by memory.
    assign issue = (state_q == RUN) && bus.fetch_en && !bus.redirect &&
                   (({1'b0, fifo_count} + {1'b0, out_q}) < (CW+1)'(DEPTH));
    assign resp_take = bus.mem_rvalid && (out_q != '0);
    assign drop      = resp_take && (disc_q != '0);
    assign keep      = resp_take && (disc_q == '0);
    assign pop       = !fifo_empty && bus.instr_ready && !bus.redirect;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        out_d  = out_q + CW'(issue) - CW'(resp_take);
        disc_d = disc_q;
        pc_d   = pc_q;
        if (bus.redirect) begin
            disc_d = out_q - CW'(resp_take);
            pc_d   = {bus.redirect_pc[31:2], 2'b00};
        end else begin
            if (drop)  disc_d = disc_q - CW'(1);
            if (issue) pc_d   = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            disc_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            disc_q <= disc_d;
            case (state_q)
                IDLE:    if (bus.fetch_en) state_q <= RUN;
                RUN:     if (!bus.fetch_en && out_q == '0) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_pc_queue (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (issue),
        .pop_i   (keep),
        .flush_i (bus.redirect),
        .data_i  ('{code: 32'h0, pc: pc_q}),
        .data_o  (pcq_head),
        .count_o (pcq_count),
        .empty_o (pcq_empty),
        .full_o  (pcq_full)
    );

    fetch_fifo #(.DEPTH(DEPTH)) u_instr_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (keep),
        .pop_i   (pop),
        .flush_i (bus.redirect),
        .data_i  ('{code: bus.mem_rdata, pc: pcq_head.pc}),
        .data_o  (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bus.mem_req     = issue;
    assign bus.mem_addr    = pc_q;
    assign bus.instr_valid = !fifo_empty;
    assign bus.instr_code  = head.code;
    assign bus.instr_pc    = head.pc;

    logic unused_ok;
    assign unused_ok = ^{pcq_head.code, pcq_count, pcq_empty, pcq_full, fifo_full,
                         bus.redirect_pc[1:0]};

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_q, stat_flushed_q;
    logic [31:0] killed;

    // A redirect kills the whole buffer plus any response landing that cycle.
    assign killed = bus.redirect ? (32'(fifo_count) + 32'(resp_take)) : 32'(drop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_fetched_q <= '0;
            stat_flushed_q <= '0;
        end else begin
            stat_fetched_q <= sat_add(stat_fetched_q, 32'(pop));
            stat_flushed_q <= sat_add(stat_flushed_q, killed);
        end
    end

    assign bus.stat_fetched = stat_fetched_q;
    assign bus.stat_flushed = stat_flushed_q;
`endif

endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- Fetch stage between the instruction memory and RV32I_core.
- Generates sequential word addresses and issues pipelined read requests to a memory with variable, in-order response latency.
- Buffers returned instructions in a small FIFO and presents them to the core with a valid/ready handshake.
- Handles PC redirects (branch/jump) by flushing the buffer and discarding stale in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries and maximum in-flight requests; power of 2, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- fetch_en  input  1  1 = fetch allowed; 0 = stop issuing new requests.
- redirect  input  1  one-cycle pulse; flush and restart at redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0).
- mem_req  output  1  read request valid this cycle (always accepted).
- mem_addr  output  32  word-aligned request address.
- mem_rvalid  input  1  response valid; responses arrive in request order, ≥1 cycle after request.
- mem_rdata  input  32  response instruction word.
- instr_valid  output  1  FIFO head valid.
- instr_ready  input  1  core consumes head when instr_valid && instr_ready.
- instr_code  output  32  head instruction.
- instr_pc  output  32  address of head instruction.

Behaviour:
- Reset values:
  - mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr_code=0, instr_pc=0.
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0; state=IDLE.
- FSM:
  - IDLE: no requests. Go to RUN when fetch_en=1.
  - RUN: issue requests. Go to IDLE when fetch_en=0 and outstanding=0; while fetch_en=0 with outstanding≠0, no new requests.
  - redirect is honoured in both states.
- Issue rule, combinational, same cycle:
  - mem_req = (state==RUN) && fetch_en && !redirect && (fifo_count + outstanding < DEPTH).
  - mem_addr = fetch_pc. Each issued request advances fetch_pc by 4 (32-bit wrap from FFFF_FFFC to 0000_0000).
- Outstanding counter:
  - +1 per request, −1 per mem_rvalid; both in the same cycle leaves it unchanged.
  - Range 0..DEPTH.
- Response handling:
  - If discard>0: drop the response, discard−1.
  - Otherwise push {rdata, pc} into the FIFO. The PC for each entry comes from a DEPTH-entry in-flight PC queue written at issue.
  - FIFO overflow is impossible by the credit rule. An assertion flags it.
- Output:
  - instr_valid = FIFO non-empty; instr_code/instr_pc = head entry, registered storage.
  - First instruction appears on instr_valid ≥2 cycles after the request (1 memory + 1 FIFO write); no combinational path from mem_rdata to instr_code.
  - Pop and push in the same cycle are both allowed, including with a full FIFO.
- Redirect (highest priority):
  - Next edge: FIFO emptied, fetch_pc = {redirect_pc[31:2], 2'b00}.
  - discard = outstanding − (mem_rvalid ? 1 : 0), i.e. counting only responses still pending after this cycle.
  - A same-cycle pop is void. No request is issued in the redirect cycle; requests to the new PC may start the following cycle while discards are still pending.
- Reset mid-operation clears everything immediately. Responses arriving after reset release with outstanding=0 are ignored, and the counter does not underflow.

Optional Feature:
- Macro FETCH_STATS_EN.
- When defined, adds outputs:
  - stat_fetched (32-bit): count of instructions accepted by the core.
  - stat_flushed (32-bit): count of FIFO entries plus discarded responses killed by redirects.
- Both counters saturate at FFFF_FFFF and reset to 0.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package rv32i_fetch_pkg:
  - typedef fetch_entry_t {logic [31:0] code; logic [31:0] pc;}
  - enum fetch_state_t {IDLE, RUN}
  - localparam PC_STEP=4
- Sub-module fetch_fifo: parameterised DEPTH, fetch_entry_t storage, push/pop/flush, count output. It is reused for the in-flight PC queue.

Test Plan:
- Reset release, fetch_en=1, 1-cycle memory, instr_ready=1 → mem_addr 0,4,8,… each cycle; instr_pc 0,4,8 in order, first instr_valid 2 cycles after first mem_req.
- instr_ready=0, 1-cycle memory → exactly DEPTH=4 requests issued (0..C), then mem_req=0; raising instr_ready resumes at address 0x10 with no loss or duplicate.
- 3-cycle latency, 3 outstanding, redirect to 0x100 → next 3 responses dropped; first instr_pc=0x100, and no old PC is ever presented.
- redirect with redirect_pc=0x203 in the same cycle as mem_rvalid and a pop → discard=outstanding−1; fetch restarts at 0x200; the popped entry is not counted twice (stat_fetched check under FETCH_STATS_EN).
- fetch_pc=FFFF_FFF8 → requests FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst low with 2 outstanding, release, and return late mem_rvalid → ignored; outstanding stays 0; first fetch at RESET_PC.
